alu_operand_stage: RTL and testbench

- Decode/issue stage that sits directly upstream of the integer ALU.
- Takes a raw RV32I/RV64I instruction and its PC, then reads the register file using combinational read addresses and same-cycle data.
- Resolves operand forwarding, selects immediates, and derives the ALU controls funct3 and invert.
- Registers the result into a single valid/ready pipeline slot that feeds the ALU operands.

---
 rtl/alu_operand_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_operand_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Decode/issue stage ahead of the integer ALU: resolves forwarded source operands,
// selects immediates, derives funct3/invert and registers one valid/ready slot.
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_ex_valid,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_funct3,
  output logic            out_invert,
  output logic [XLEN-1:0] out_operand_1,
  output logic [XLEN-1:0] out_operand_2,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // A matching forward implies rs != 0, so an rd==0 forward can never win.
  function automatic logic [XLEN-1:0] resolve_src(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_v,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_v,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == 5'd0)                     return '0;
    else if (ex_v && (ex_rd == rs))     return ex_data;
    else if (wb_v && (wb_rd == rs))     return wb_data;
    else                                return rf_data;
  endfunction

  function automatic logic [XLEN-1:0] sext_i_imm(input logic [31:0] instr);
    logic signed [11:0] imm;
    imm = instr[31:20];
    return XLEN'(imm);
  endfunction

  function automatic logic [XLEN-1:0] sext_u_imm(input logic [31:0] instr);
    logic signed [31:0] imm;
    imm = {instr[31:12], 12'b0};
    return XLEN'(imm);
  endfunction

  logic            valid_q, valid_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            invert_q, invert_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] src1, src2;
  logic            capture;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];

  assign src1 = resolve_src(rs1_addr, rs1_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                            fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign src2 = resolve_src(rs2_addr, rs2_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                            fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    funct3_d  = 3'b000;
    invert_d  = 1'b0;
    op1_d     = '0;
    op2_d     = '0;
    rd_d      = 5'd0;
    illegal_d = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        funct3_d = f3;
        invert_d = ((f3 == 3'b000) || (f3 == 3'b101)) ? in_instr[30] : 1'b0;
        op1_d    = src1;
        op2_d    = src2;
        rd_d     = in_instr[11:7];
      end
      OPC_OP_IMM: begin
        // No SUBI: bit 30 only selects arithmetic right shift; the ALU masks the shamt.
        funct3_d = f3;
        invert_d = (f3 == 3'b101) ? in_instr[30] : 1'b0;
        op1_d    = src1;
        op2_d    = sext_i_imm(in_instr);
        rd_d     = in_instr[11:7];
      end
      OPC_LUI: begin
        op2_d = sext_u_imm(in_instr);
        rd_d  = in_instr[11:7];
      end
      OPC_AUIPC: begin
        op1_d = in_pc;
        op2_d = sext_u_imm(in_instr);
        rd_d  = in_instr[11:7];
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Flush beats capture and hold; a drained slot with no capture empties.
  always_comb begin
    valid_d = valid_q;
    if (flush)             valid_d = 1'b0;
    else if (capture)      valid_d = 1'b1;
    else if (out_ready)    valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      funct3_q  <= 3'b000;
      invert_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        funct3_q  <= funct3_d;
        invert_q  <= invert_d;
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        rd_q      <= rd_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_funct3    = funct3_q;
  assign out_invert    = invert_q;
  assign out_operand_1 = op1_q;
  assign out_operand_2 = op2_q;
  assign out_rd        = rd_q;
  assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage (XLEN=32): vector table plus handshake,
// flush and asynchronous-reset sequences.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        fwd_ex_valid;
  logic [4:0]  fwd_ex_rd;
  logic [31:0] fwd_ex_data;
  logic        fwd_wb_valid;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_funct3;
  logic        out_invert;
  logic [31:0] out_operand_1, out_operand_2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;

  alu_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_funct3(out_funct3), .out_invert(out_invert),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [2:0]  f3;
    logic        inv;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [2:0] f3,
                          input logic inv, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [4:0] rd, input logic ill);
    chk({tag, ".valid"},   32'(out_valid),   32'(v));
    chk({tag, ".funct3"},  32'(out_funct3),  32'(f3));
    chk({tag, ".invert"},  32'(out_invert),  32'(inv));
    chk({tag, ".op1"},     out_operand_1,    op1);
    chk({tag, ".op2"},     out_operand_2,    op2);
    chk({tag, ".rd"},      32'(out_rd),      32'(rd));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_instr     = v.instr;
    in_pc        = v.pc;
    rs1_data     = v.rs1;
    rs2_data     = v.rs2;
    fwd_ex_valid = v.exv;
    fwd_ex_rd    = v.exrd;
    fwd_ex_data  = v.exd;
    fwd_wb_valid = v.wbv;
    fwd_wb_rd    = v.wbrd;
    fwd_wb_data  = v.wbd;
  endtask

  initial begin
    vec_t tmp;
    logic [31:0] ins;
    //          name          instr         pc          rs1           rs2         exv exrd exd          wbv wbrd wbd          f3    inv op1           op2           rd ill
    vt[0]  = '{"add",        32'h002081B3, 32'h0,      32'd5,        32'd7,      0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'd5,        32'd7,        3, 0};
    vt[1]  = '{"sub_fwd_ex", 32'h402081B3, 32'h0,      32'h111,      32'h222,    1, 1, 32'h10,       1, 1, 32'h20,       3'd0, 1, 32'h10,       32'h222,      3, 0};
    vt[2]  = '{"fwd_wb",     32'h002081B3, 32'h0,      32'hA,        32'hB,      1, 5, 32'h55,       1, 2, 32'h77,       3'd0, 0, 32'hA,        32'h77,       3, 0};
    vt[3]  = '{"fwd_off",    32'h002081B3, 32'h0,      32'd1,        32'd2,      0, 1, 32'h99,       0, 2, 32'h88,       3'd0, 0, 32'd1,        32'd2,        3, 0};
    vt[4]  = '{"x0_src",     32'h002001B3, 32'h0,      32'h123,      32'd4,      1, 0, 32'hDEAD,     1, 0, 32'hBEEF,     3'd0, 0, 32'h0,        32'd4,        3, 0};
    vt[5]  = '{"srai",       32'h40435293, 32'h0,      32'h80000000, 32'd3,      0, 0, 32'h0,        0, 0, 32'h0,        3'd5, 1, 32'h80000000, 32'h404,      5, 0};
    vt[6]  = '{"addi_m1",    32'hFFF00093, 32'h0,      32'h55,       32'h66,     0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'h0,        32'hFFFFFFFF, 1, 0};
    vt[7]  = '{"addi_b30",   32'h40010093, 32'h0,      32'd9,        32'd0,      0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'd9,        32'h400,      1, 0};
    vt[8]  = '{"auipc",      32'h12345097, 32'h1000,   32'h5,        32'h6,      0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'h1000,     32'h12345000, 1, 0};
    vt[9]  = '{"lui",        32'h800003B7, 32'h2000,   32'h77,       32'h0,      0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'h0,        32'h80000000, 7, 0};
    vt[10] = '{"illegal",    32'h123450F3, 32'h3000,   32'h44,       32'h45,     0, 0, 32'h0,        0, 0, 32'h0,        3'd0, 0, 32'h0,        32'h0,        0, 1};
    vt[11] = '{"sra",        32'h4020D233, 32'h0,      32'hF0,       32'd4,      0, 0, 32'h0,        0, 0, 32'h0,        3'd5, 1, 32'hF0,       32'd4,        4, 0};
    vt[12] = '{"or_b30",     32'h4020E233, 32'h0,      32'hF0,       32'h0F,     0, 0, 32'h0,        0, 0, 32'h0,        3'd6, 0, 32'hF0,       32'h0F,       4, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tmp = vt[0];
    drive(tmp);
    #12;
    chk_outs("reset", 0, 3'd0, 0, 32'h0, 32'h0, 5'd0, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back table, one instruction per cycle
    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      in_valid = 1'b1;
      #1;
      ins = vt[i].instr;
      chk({vt[i].name, ".rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
      chk({vt[i].name, ".rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
      chk({vt[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
      step();
      chk_outs(vt[i].name, 1, vt[i].f3, vt[i].inv, vt[i].op1, vt[i].op2, vt[i].rd, vt[i].ill);
    end
    in_valid = 1'b0;
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: hold ADD for 3 cycles while SUB waits, then swap with no bubble
    drive(vt[0]);
    in_valid = 1'b1;
    step();
    chk_outs("bp_cap", 1, 3'd0, 0, 32'd5, 32'd7, 5'd3, 0);
    out_ready = 1'b0;
    drive(vt[1]);
    for (int c = 0; c < 3; c++) begin
      fwd_ex_data = 32'h1000 + 32'(c);
      #1;
      chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
      step();
      chk_outs("bp_hold", 1, 3'd0, 0, 32'd5, 32'd7, 5'd3, 0);
    end
    drive(vt[1]);
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    step();
    chk_outs("bp_swap", 1, 3'd0, 1, 32'h10, 32'h222, 5'd3, 0);

    // Flush while holding, with a capture offered in the same cycle
    out_ready = 1'b0;
    drive(vt[8]);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    chk("flush.valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_after.valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a hold
    out_ready = 1'b1;
    drive(vt[5]);
    in_valid = 1'b1;
    step();
    chk_outs("pre_rst", 1, 3'd5, 1, 32'h80000000, 32'h404, 5'd5, 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 0, 3'd0, 0, 32'h0, 32'h0, 5'd0, 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst.valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
